stg_player_ctrl: RTL and testbench

Consumes the held-key levels (w, s, a, d, z, x, enter) from the PS/2 keyboard decoder and turns them into game control. It runs the top-level game-state FSM (title/play/pause/over) from enter press edges. Once per video frame it updates the player ship position, with focus (slow) mode and playfield clamping. It also issues rate-limited shot requests to the bullet spawner.

---
 rtl/stg_player_ctrl.sv | 146 ++++++++++++++
 tb/tb_stg_player_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stg_player_ctrl.sv
// Player control for the shooter: game-state FSM driven by enter presses,
// per-frame ship movement with focus mode and clamping, and rate-limited fire.
module stg_player_ctrl #(
  parameter int X_MIN    = 16,
  parameter int X_MAX    = 368,
  parameter int Y_MIN    = 16,
  parameter int Y_MAX    = 464,
  parameter int X_INIT   = 192,
  parameter int Y_INIT   = 400,
  parameter int SPD_FAST = 4,
  parameter int SPD_SLOW = 2,
  parameter int FIRE_CD  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       w,
  input  logic       s,
  input  logic       a,
  input  logic       d,
  input  logic       z,
  input  logic       x,
  input  logic       enter,
  input  logic       hit,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       focus,
  output logic       fire_req,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Cooldown only ever holds 0..FIRE_CD-1.
  localparam int CD_W = (FIRE_CD > 1) ? $clog2(FIRE_CD) : 1;

  state_e            state_q, state_d;
  logic [9:0]        px_q, px_d;
  logic [9:0]        py_q, py_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              fire_q, fire_d;
  logic              focus_q, focus_d;
  logic              enter_prev_q, enter_prev_d;

  logic              enter_pr;
  logic              play_tick;
  logic signed [10:0] step, dx, dy, x_sum, y_sum;
  logic [9:0]        x_new, y_new;

  assign enter_pr  = enter & ~enter_prev_q;
  assign play_tick = frame_tick & (state_q == ST_PLAY);

  // Candidate position for this frame; only committed on a PLAY tick.
  always_comb begin
    step = x ? 11'(SPD_SLOW) : 11'(SPD_FAST);
    dx   = '0;
    dy   = '0;
    if (d & ~a) dx = step;
    else if (a & ~d) dx = -step;
    if (s & ~w) dy = step;
    else if (w & ~s) dy = -step;

    x_sum = $signed({1'b0, px_q}) + dx;
    y_sum = $signed({1'b0, py_q}) + dy;

    if (x_sum < $signed(11'(X_MIN)))      x_new = 10'(X_MIN);
    else if (x_sum > $signed(11'(X_MAX))) x_new = 10'(X_MAX);
    else                                  x_new = x_sum[9:0];

    if (y_sum < $signed(11'(Y_MIN)))      y_new = 10'(Y_MIN);
    else if (y_sum > $signed(11'(Y_MAX))) y_new = 10'(Y_MAX);
    else                                  y_new = y_sum[9:0];
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    cd_d         = cd_q;
    fire_d       = 1'b0;
    focus_d      = x & (state_q == ST_PLAY);
    enter_prev_d = enter;

    unique case (state_q)
      ST_TITLE: if (enter_pr) begin
        state_d = ST_PLAY;
        px_d    = 10'(X_INIT);
        py_d    = 10'(Y_INIT);
        cd_d    = '0;
      end
      ST_PLAY: begin
        if (hit)           state_d = ST_OVER;
        else if (enter_pr) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (enter_pr) state_d = ST_PLAY;
      ST_OVER:  if (enter_pr) state_d = ST_TITLE;
      default:  state_d = ST_TITLE;
    endcase

    // A tick that coincides with leaving PLAY still moves and fires.
    if (play_tick) begin
      px_d = x_new;
      py_d = y_new;
      if (cd_q != '0) begin
        cd_d = cd_q - 1'b1;
      end else if (z) begin
        fire_d = 1'b1;
        cd_d   = CD_W'(FIRE_CD - 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_TITLE;
      px_q         <= 10'(X_INIT);
      py_q         <= 10'(Y_INIT);
      cd_q         <= '0;
      fire_q       <= 1'b0;
      focus_q      <= 1'b0;
      enter_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      cd_q         <= cd_d;
      fire_q       <= fire_d;
      focus_q      <= focus_d;
      enter_prev_q <= enter_prev_d;
    end
  end

  assign player_x   = px_q;
  assign player_y   = py_q;
  assign focus      = focus_q;
  assign fire_req   = fire_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_stg_player_ctrl.sv
// Self-checking bench for stg_player_ctrl: directed scenarios followed by
// randomized key/tick traffic, all compared against a behavioural game model.
module tb_stg_player_ctrl;

  localparam int X_MIN = 16, X_MAX = 368, Y_MIN = 16, Y_MAX = 464;
  localparam int X_INIT = 192, Y_INIT = 400;
  localparam int SPD_FAST = 4, SPD_SLOW = 2, FIRE_CD = 6;
  localparam int TITLE = 0, PLAY = 1, PAUSE = 2, OVER = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, w, s, a, d, z, x, enter, hit;
  logic [9:0] player_x, player_y;
  logic       focus, fire_req;
  logic [1:0] game_state;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the game
  int m_state, m_x, m_y, m_cd;
  bit m_fire, m_focus, m_enter_prev;

  stg_player_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .w          (w),
    .s          (s),
    .a          (a),
    .d          (d),
    .z          (z),
    .x          (x),
    .enter      (enter),
    .hit        (hit),
    .player_x   (player_x),
    .player_y   (player_y),
    .focus      (focus),
    .fire_req   (fire_req),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_state = TITLE; m_x = X_INIT; m_y = Y_INIT; m_cd = 0;
    m_fire = 0; m_focus = 0; m_enter_prev = 1;
  endtask

  task automatic model_step();
    int  ns, spd, mvx, mvy;
    bit  press;
    press  = enter && !m_enter_prev;
    ns     = m_state;
    m_fire = 0;
    case (m_state)
      TITLE: if (press) begin ns = PLAY; m_x = X_INIT; m_y = Y_INIT; m_cd = 0; end
      PLAY:  if (hit) ns = OVER; else if (press) ns = PAUSE;
      PAUSE: if (press) ns = PLAY;
      default: if (press) ns = TITLE;
    endcase
    if (frame_tick && m_state == PLAY) begin
      spd = x ? SPD_SLOW : SPD_FAST;
      mvx = (d && !a) ? spd : ((a && !d) ? -spd : 0);
      mvy = (s && !w) ? spd : ((w && !s) ? -spd : 0);
      m_x = clamp(m_x + mvx, X_MIN, X_MAX);
      m_y = clamp(m_y + mvy, Y_MIN, Y_MAX);
      if (m_cd > 0) m_cd--;
      else if (z) begin m_fire = 1; m_cd = FIRE_CD - 1; end
    end
    m_focus      = x && (m_state == PLAY);
    m_enter_prev = enter;
    m_state      = ns;
  endtask

  task automatic compare_all();
    check("game_state", 16'(game_state), 16'(m_state));
    check("player_x",   16'(player_x),   16'(m_x));
    check("player_y",   16'(player_y),   16'(m_y));
    check("focus",      16'(focus),      16'(m_focus));
    check("fire_req",   16'(fire_req),   16'(m_fire));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    cycle();
    enter = 1'b0;
    cycle();
  endtask

  task automatic keys(input bit kw, input bit ks, input bit ka, input bit kd,
                      input bit kz, input bit kx);
    w = kw; s = ks; a = ka; d = kd; z = kz; x = kx;
  endtask

  initial begin
    int fires;
    rst = 1'b1; frame_tick = 0; hit = 0; enter = 1'b1;
    keys(0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    compare_all();
    check("rst_x", 16'(player_x), 16'd192);
    repeat (3) cycle();
    rst = 1'b0;

    // enter held through reset gives no press
    repeat (3) cycle();
    check("title_hold", 16'(game_state), 16'(TITLE));
    enter = 1'b0;
    repeat (2) cycle();
    enter = 1'b1;
    cycle();
    check("title_to_play", 16'(game_state), 16'(PLAY));
    check("start_x", 16'(player_x), 16'd192);
    check("start_y", 16'(player_y), 16'd400);
    enter = 1'b0;
    cycle();

    // Right movement, then focus speed
    keys(0, 0, 0, 1, 0, 0);
    tick(); check("move_x1", 16'(player_x), 16'd196); cycle();
    tick(); check("move_x2", 16'(player_x), 16'd200); cycle();
    tick(); check("move_x3", 16'(player_x), 16'd204); cycle();
    keys(0, 0, 0, 1, 0, 1);
    cycle();
    tick(); check("focus_x", 16'(player_x), 16'd206);
    check("focus_on", 16'(focus), 16'd1);
    cycle();

    // Left clamp: 206 -> 18 in 47 fast steps, then one more clamps to 16
    keys(0, 0, 1, 0, 0, 0);
    repeat (47) begin tick(); cycle(); end
    check("x_at_18", 16'(player_x), 16'd18);
    tick(); check("x_clamp_min", 16'(player_x), 16'd16); cycle();

    // Bottom clamp: 400 -> 460 fast, -> 462 slow, then clamp at 464
    keys(0, 1, 0, 0, 0, 0);
    repeat (15) begin tick(); cycle(); end
    keys(0, 1, 0, 0, 0, 1);
    tick(); check("y_at_462", 16'(player_y), 16'd462); cycle();
    keys(0, 1, 0, 0, 0, 0);
    tick(); check("y_clamp_max", 16'(player_y), 16'd464); cycle();

    // Fire cadence with z held for 13 ticks
    keys(0, 0, 0, 0, 1, 0);
    fires = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("fire_tick%0d", i), 16'(fire_req), 16'((i % FIRE_CD) == 0));
      if (fire_req) fires++;
      cycle();
      check("fire_width", 16'(fire_req), 16'd0);
    end
    check("fire_count", 16'(fires), 16'd3);

    // Pause freezes motion and cooldown (frozen at FIRE_CD-1)
    keys(0, 0, 0, 0, 0, 0);
    press_enter();
    check("to_pause", 16'(game_state), 16'(PAUSE));
    keys(0, 0, 0, 1, 1, 0);
    repeat (5) begin
      tick();
      check("pause_x", 16'(player_x), 16'd16);
      check("pause_fire", 16'(fire_req), 16'd0);
      cycle();
    end
    press_enter();
    check("resume_play", 16'(game_state), 16'(PLAY));
    keys(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < FIRE_CD; i++) begin
      tick();
      check($sformatf("resume_fire%0d", i), 16'(fire_req), 16'(i == FIRE_CD - 1));
      cycle();
    end

    // hit beats enter press in the same cycle
    keys(0, 0, 0, 0, 0, 0);
    hit = 1'b1; enter = 1'b1;
    cycle();
    hit = 1'b0; enter = 1'b0;
    check("hit_over", 16'(game_state), 16'(OVER));
    cycle();
    press_enter();
    check("over_title", 16'(game_state), 16'(TITLE));
    press_enter();
    check("replay", 16'(game_state), 16'(PLAY));
    check("replay_x", 16'(player_x), 16'd192);
    check("replay_y", 16'(player_y), 16'd400);

    // Asynchronous reset in the middle of a cycle
    keys(0, 0, 0, 1, 1, 1);
    tick();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    repeat (2) cycle();
    enter = 1'b1;
    #1 rst = 1'b0;
    repeat (3) cycle();
    check("post_rst_fire", 16'(fire_req), 16'd0);
    enter = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0)
        keys(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      frame_tick = ($urandom_range(0, 3) == 0);
      hit        = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) enter = ~enter;
      cycle();
    end
    frame_tick = 0; hit = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
